sme_feeder: RTL and testbench
=============================

# sme_feeder

Upstream framing stage for the string-matching engine. Accepts string and pattern characters from a host byte stream using a valid/ready handshake, and buffers one complete string record (up to 32 chars) and one pattern record (up to 8 chars). It replays them to the engine as the contiguous `isstring`/`ispattern` bursts the engine requires, then holds off the host until the engine reports `valid` for that pattern.

## Interface

Parameters:
- `GAP`, default 1: idle cycles inserted after engine `valid` before the next burst may start; legal range 1..7.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host beat valid.
- `in_ready`  out  1  feeder accepts a beat; a beat transfers when `in_valid & in_ready`.
- `in_data`  in  8  ASCII character.
- `in_type`  in  1  record type, sampled on the first beat of a record only: 0 = string, 1 = pattern.
- `in_last`  in  1  last beat of the current record.
- `chardata`  out  8  character to the engine.
- `isstring`  out  1  string burst strobe to the engine.
- `ispattern`  out  1  pattern burst strobe to the engine.
- `sme_valid`  in  1  engine result-valid pulse.
- `busy`  out  1  high in SEND_S, SEND_P, WAIT and GAP.
- `ovf_err`  out  1  one-cycle pulse on the first dropped beat of an over-length record.

## Operation

- Storage:
  - `sbuf` is 32x8 with a 6-bit length `slen` (0..32).
  - `pbuf` is 8x8 with a 4-bit length `plen` (0..8).
  - `s_pending` flag: a string record is buffered and not yet sent.
- States:
  - IDLE: `in_ready`=1. The first accepted beat goes to COLLECT_S (`in_type`=0) or COLLECT_P (`in_type`=1), clears that record's length, and stores the beat at index 0. If that beat also has `in_last`, it is handled as the last beat of the record, as below.
  - COLLECT_S: each beat is written at `sbuf[slen]`, then `slen++`. Beats beyond 32 are accepted and dropped; `ovf_err` pulses on the first dropped beat. On `in_last`: set `s_pending`, go to IDLE.
  - COLLECT_P: same behaviour on `pbuf`, capped at 8. On `in_last`: go to SEND_S if `s_pending`, else SEND_P.
  - SEND_S: drive `sbuf[0..slen-1]` with `isstring`=1, one char per cycle. After the last char go directly to SEND_P with no gap, and clear `s_pending`.
  - SEND_P: drive `pbuf[0..plen-1]` with `ispattern`=1. After the last char go to WAIT.
  - WAIT: `isstring`=`ispattern`=0 and `chardata`=0. On `sme_valid`, go to GAP.
  - GAP: count `GAP` cycles, then go to IDLE.
- `in_type` on non-first beats is ignored.
- A second string record arriving while `s_pending` is set overwrites `sbuf`/`slen`.
- A pattern record with no preceding string record is sent alone and reuses the engine's stored string.
- `sme_valid` outside WAIT is ignored.
- `pbuf` and `sbuf` are retained after sending. `slen` is retained, but the string is only resent if a new string record arrives.

## Timing

- All outputs are registered.
- Reset values: `in_ready`=0, `chardata`=0, `isstring`=0, `ispattern`=0, `busy`=0, `ovf_err`=0. Internal reset values: state IDLE, `s_pending`=0, lengths 0.
- `in_ready` rises on the first clock after reset deasserts.
- Pattern `in_last` accepted at cycle T:
  - `in_ready`=0 and `busy`=1 from T+1.
  - The first `isstring` (or `ispattern`) char appears at T+1.
- The `isstring` burst is exactly `slen` cycles. `ispattern` asserts the cycle after the last string char; the burst is exactly `plen` cycles.
- `isstring` and `ispattern` are never high together.
- `sme_valid` sampled high at cycle V:
  - GAP spans V+1..V+GAP.
  - `in_ready`=1 and `busy`=0 at V+GAP+1.
- Reset asserted mid-operation: all outputs go to reset values asynchronously and `s_pending` clears. Any partial record is discarded.
- Throughput: one host beat per cycle during collection.

## Test plan

- **String then pattern:** string "ab cd" with `in_last` on 'd', then pattern "^cd" with `in_last`.
  - `isstring` high 5 cycles carrying 61,62,20,63,64, immediately followed by `ispattern` high 3 cycles carrying 5E,63,64.
  - `in_ready`=0 from the cycle after pattern `in_last`.
- **Release after valid, GAP=1:** pulse `sme_valid` in WAIT at cycle V.
  - `in_ready` returns to 1 at V+2.
  - `sme_valid` pulsed while in IDLE or COLLECT has no effect.
- **Pattern-only record:** pattern "x*y" with no preceding string record.
  - No `isstring` cycle.
  - `ispattern` for 3 cycles: 78,2A,79.
- **String overflow:** string of 35 chars 'A'+i.
  - `ovf_err` pulses once, on beat 33.
  - A subsequent pattern triggers exactly 32 `isstring` cycles ending with char 'A'+31.
- **Overwrite and single-beat record:** two string records, "zz" then "q", then single-beat pattern "q" (`in_last` on the first beat).
  - Only "q" is sent: 1 `isstring` cycle (71) then 1 `ispattern` cycle (71).
- **Reset mid-SEND_S:** assert `reset` during SEND_S.
  - All outputs go to 0 immediately.
  - After release, `in_ready`=1 next clock; a lone pattern record sends no string.

Source files
------------

// File: rtl/sme_feeder.sv
// Framing stage for the string-matching engine: buffers one string and one
// pattern record from the host, replays them as contiguous engine bursts.
`timescale 1ns/1ps
module sme_feeder #(
  parameter int unsigned GAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_type,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  output logic       busy,
  output logic       ovf_err
);

  typedef enum logic [2:0] {
    IDLE, COLLECT_S, COLLECT_P, SEND_S, SEND_P, WAIT, GAP_S
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  slen_q, slen_d;
  logic [3:0]  plen_q, plen_d;
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  gap_cnt_q, gap_cnt_d;
  logic        s_pending_q, s_pending_d;
  logic        ovf_seen_q, ovf_seen_d;
  logic [7:0]  chardata_d;
  logic        isstring_d, ispattern_d, ovf_err_d, in_ready_d, busy_d;

  logic [7:0]  sbuf_q [32];
  logic [7:0]  pbuf_q [8];
  logic        s_we, p_we, launch, beat;
  logic [4:0]  s_waddr;
  logic [2:0]  p_waddr;

  // Handshake: a beat transfers on a rising edge where in_valid & in_ready;
  // in_ready is registered and only high in IDLE/COLLECT states.
  assign beat = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    slen_d      = slen_q;
    plen_d      = plen_q;
    idx_d       = idx_q;
    gap_cnt_d   = gap_cnt_q;
    s_pending_d = s_pending_q;
    ovf_seen_d  = ovf_seen_q;
    chardata_d  = 8'h00;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    ovf_err_d   = 1'b0;
    s_we        = 1'b0;
    p_we        = 1'b0;
    s_waddr     = slen_q[4:0];
    p_waddr     = plen_q[2:0];
    launch      = 1'b0;
    case (state_q)
      IDLE: if (beat) begin
        ovf_seen_d = 1'b0;
        if (!in_type) begin
          s_we    = 1'b1;
          s_waddr = 5'd0;
          slen_d  = 6'd1;
          if (in_last) s_pending_d = 1'b1;
          else         state_d     = COLLECT_S;
        end else begin
          p_we    = 1'b1;
          p_waddr = 3'd0;
          plen_d  = 4'd1;
          if (in_last) launch  = 1'b1;
          else         state_d = COLLECT_P;
        end
      end
      COLLECT_S: if (beat) begin
        if (slen_q < 6'd32) begin
          s_we   = 1'b1;
          slen_d = slen_q + 6'd1;
        end else if (!ovf_seen_q) begin
          ovf_err_d  = 1'b1;
          ovf_seen_d = 1'b1;
        end
        if (in_last) begin
          s_pending_d = 1'b1;
          state_d     = IDLE;
        end
      end
      COLLECT_P: if (beat) begin
        if (plen_q < 4'd8) begin
          p_we   = 1'b1;
          plen_d = plen_q + 4'd1;
        end else if (!ovf_seen_q) begin
          ovf_err_d  = 1'b1;
          ovf_seen_d = 1'b1;
        end
        if (in_last) launch = 1'b1;
      end
      SEND_S: begin
        if (idx_q == slen_q) begin
          state_d     = SEND_P;
          s_pending_d = 1'b0;
          chardata_d  = pbuf_q[0];
          ispattern_d = 1'b1;
          idx_d       = 6'd1;
        end else begin
          chardata_d = sbuf_q[idx_q[4:0]];
          isstring_d = 1'b1;
          idx_d      = idx_q + 6'd1;
        end
      end
      SEND_P: begin
        if (idx_q == {2'b00, plen_q}) begin
          state_d = WAIT;
        end else begin
          chardata_d  = pbuf_q[idx_q[2:0]];
          ispattern_d = 1'b1;
          idx_d       = idx_q + 6'd1;
        end
      end
      WAIT: if (sme_valid) begin
        state_d   = GAP_S;
        gap_cnt_d = 3'd0;
      end
      GAP_S: begin
        if (gap_cnt_q == 3'(GAP - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
    // First burst char leaves on the edge that accepts the pattern's last
    // beat; a single-beat pattern has pbuf[0] still in flight, so bypass it.
    if (launch) begin
      idx_d = 6'd1;
      if (s_pending_q) begin
        state_d    = SEND_S;
        chardata_d = sbuf_q[0];
        isstring_d = 1'b1;
      end else begin
        state_d     = SEND_P;
        chardata_d  = (state_q == IDLE) ? in_data : pbuf_q[0];
        ispattern_d = 1'b1;
      end
    end
    in_ready_d = (state_d == IDLE) || (state_d == COLLECT_S) || (state_d == COLLECT_P);
    busy_d     = !in_ready_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      slen_q      <= 6'd0;
      plen_q      <= 4'd0;
      idx_q       <= 6'd0;
      gap_cnt_q   <= 3'd0;
      s_pending_q <= 1'b0;
      ovf_seen_q  <= 1'b0;
      chardata    <= 8'h00;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      ovf_err     <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      slen_q      <= slen_d;
      plen_q      <= plen_d;
      idx_q       <= idx_d;
      gap_cnt_q   <= gap_cnt_d;
      s_pending_q <= s_pending_d;
      ovf_seen_q  <= ovf_seen_d;
      chardata    <= chardata_d;
      isstring    <= isstring_d;
      ispattern   <= ispattern_d;
      ovf_err     <= ovf_err_d;
      in_ready    <= in_ready_d;
      busy        <= busy_d;
    end
  end

  // Record storage carries no reset; lengths alone define valid contents.
  always_ff @(posedge clk) begin
    if (s_we) sbuf_q[s_waddr] <= in_data;
    if (p_we) pbuf_q[p_waddr] <= in_data;
  end

endmodule

// File: tb/tb_sme_feeder.sv
// Directed plus randomized bench for sme_feeder with a queue-based model of
// the string/pattern records the engine should receive.
`timescale 1ns/1ps
module tb_sme_feeder;
  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_type = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid = 1'b0;
  logic       busy;
  logic       ovf_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] rec_q[$];
  logic [7:0] str_m[$];
  bit         pend_m = 1'b0;
  logic [9:0] exp_q[$];

  sme_feeder #(.GAP(GAP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_type(in_type), .in_last(in_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_str(input string s);
    rec_q.delete();
    for (int i = 0; i < s.len(); i++) rec_q.push_back(s[i]);
  endtask

  task automatic load_rand(input int n);
    rec_q.delete();
    for (int i = 0; i < n; i++) rec_q.push_back(8'($urandom_range(32, 126)));
  endtask

  // Drives rec_q back to back; in_type is randomized on non-first beats.
  task automatic send_record(input bit typ, output int hits, output int obeat, output int stalls);
    int n;
    int w;
    n = rec_q.size();
    hits = 0; obeat = 0; stalls = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = rec_q[i];
      in_type  = (i == 0) ? typ : 1'($urandom_range(0, 1));
      in_last  = (i == n - 1);
      w = 0;
      while (!in_ready && w < 50) begin
        stalls++; w++;
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (ovf_err) begin
        hits++;
        if (obeat == 0) obeat = i + 1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_type  = 1'b0;
  endtask

  task automatic host_string();
    int hits, obeat, stalls, n;
    n = rec_q.size();
    send_record(1'b0, hits, obeat, stalls);
    check("str_stalls", stalls, 0);
    check("str_ovf_hits", hits, (n > 32) ? 1 : 0);
    check("str_ovf_beat", obeat, (n > 32) ? 33 : 0);
    str_m.delete();
    for (int i = 0; i < n && i < 32; i++) str_m.push_back(rec_q[i]);
    pend_m = 1'b1;
  endtask

  task automatic check_burst();
    logic [9:0] e;
    check("in_ready_after_last", in_ready, 0);
    check("busy_after_last", busy, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("burst", {isstring, ispattern, chardata}, e);
      @(posedge clk); #1;
    end
  endtask

  task automatic release_engine();
    int w;
    w = $urandom_range(0, 3);
    repeat (w) begin
      check("wait_quiet", {isstring, ispattern, chardata, busy, in_ready}, {10'h000, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    sme_valid = 1'b1;
    @(posedge clk); #1;
    sme_valid = 1'b0;
    repeat (GAP) begin
      check("gap_hold", {busy, in_ready}, 2'b10);
      @(posedge clk); #1;
    end
    check("released", {busy, in_ready}, 2'b01);
  endtask

  // Pattern record: expected engine stream is pending string, then pattern,
  // then a quiet WAIT cycle.
  task automatic host_pattern(input bit do_release);
    int hits, obeat, stalls, n;
    n = rec_q.size();
    exp_q.delete();
    if (pend_m) foreach (str_m[i]) exp_q.push_back({2'b10, str_m[i]});
    for (int i = 0; i < n && i < 8; i++) exp_q.push_back({2'b01, rec_q[i]});
    exp_q.push_back(10'h000);
    pend_m = 1'b0;
    send_record(1'b1, hits, obeat, stalls);
    check("pat_stalls", stalls, 0);
    check("pat_ovf_hits", hits, (n > 8) ? 1 : 0);
    check("pat_ovf_beat", obeat, (n > 8) ? 9 : 0);
    if (do_release) begin
      check_burst();
      release_engine();
    end
  endtask

  initial begin
    int hits, obeat, stalls;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {in_ready, chardata, isstring, ispattern, busy, ovf_err}, 13'h0);
    reset = 1'b1;
    check("ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("ready_after_reset", {in_ready, busy}, 2'b10);

    sme_valid = 1'b1;
    @(posedge clk); #1;
    sme_valid = 1'b0;
    @(posedge clk); #1;
    check("valid_in_idle", {in_ready, busy, isstring, ispattern}, 4'b1000);

    load_str("x*y");
    host_pattern(1'b1);

    sme_valid = 1'b1;
    load_str("ab cd");
    host_string();
    sme_valid = 1'b0;
    load_str("^cd");
    host_pattern(1'b1);

    load_rand(0);
    for (int i = 0; i < 35; i++) rec_q.push_back(8'(8'h41 + i));
    host_string();
    load_str("Z");
    host_pattern(1'b1);

    load_str("zz");
    host_string();
    load_str("q");
    host_string();
    load_str("q");
    host_pattern(1'b1);

    for (int it = 0; it < 25; it++) begin
      int ns;
      ns = $urandom_range(0, 2);
      for (int k = 0; k < ns; k++) begin
        load_rand($urandom_range(1, 40));
        host_string();
      end
      load_rand($urandom_range(1, 10));
      host_pattern(1'b1);
    end

    load_str("hello");
    host_string();
    load_str("lo");
    host_pattern(1'b0);
    check("send_s_first", {isstring, ispattern, chardata}, {2'b10, 8'h68});
    @(posedge clk); #1;
    check("send_s_second", {isstring, ispattern, chardata}, {2'b10, 8'h65});
    reset = 1'b0;
    #1;
    check("async_reset", {in_ready, chardata, isstring, ispattern, busy, ovf_err}, 13'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    pend_m = 1'b0;
    @(posedge clk); #1;
    check("ready_after_midreset", {in_ready, busy}, 2'b10);
    load_str("ok");
    host_pattern(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
